// File: rtl/fetch_pkg.sv
// Shared types, constants and sizing helpers for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Entry layout at the default 32-bit PC width; fetch_unit mirrors it at XLEN.
  localparam int unsigned ENTRY_XLEN = 32;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  fault;
  } fetch_entry_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush, register-array head and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = count_width(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  assign head_valid = (cnt != '0);
  assign head_data  = mem[rd_ptr];
  assign count      = cnt;
  assign do_pop     = pop & head_valid;

  // A flush discards everything; a push in the same cycle becomes the sole entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wr_ptr <= PW'(1);
        cnt    <= CW'(1);
      end else begin
        wr_ptr <= '0;
        cnt    <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  fetch_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (do_pop),
    .flush   (flush),
    .count   (cnt)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checks for fetch_fifo; the issue rule must make a push into a full buffer impossible.
module fetch_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset_n,
  input logic          push,
  input logic          pop,
  input logic          flush,
  input logic [CW-1:0] count
);

  no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(push && !pop && !flush && (count == CW'(DEPTH)))
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem read per cycle and buffers
// returned words for decode, with redirect flush and misaligned-target fault entries.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_fault
);

  localparam int unsigned CW = count_width(FIFO_DEPTH);
  localparam int unsigned EW = XLEN + 33;
  localparam logic [CW:0] DEPTH_LIM = FIFO_DEPTH[CW:0];

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } entry_t;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            issue;
  logic            push;
  logic            misaligned;
  entry_t          push_entry;
  entry_t          head_entry;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;

  // Buffered plus in-flight work must never exceed the buffer, so overflow cannot occur.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // Next state, issue decision and FIFO write source.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (redirect_valid) begin
      state_next = misaligned ? FAULT : RUN;
      push       = misaligned;
      push_entry = '{pc: redirect_pc, instr: NOP_INSTR, fault: 1'b1};
    end else begin
      push       = imem_resp_valid & inflight;
      push_entry = '{pc: req_pc, instr: imem_resp_data, fault: 1'b0};
      case (state)
        RUN:     issue = reset_n & (occupancy < DEPTH_LIM);
        FAULT:   issue = 1'b0;
        default: issue = 1'b0;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // PC and the single outstanding request it produced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_VECTOR;
      req_pc   <= RESET_VECTOR;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) pc <= redirect_pc;
      else if (issue)     pc <= pc + XLEN'(4);
      if (issue) req_pc <= pc;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head_data  (head_entry),
    .count      (count)
  );

  assign imem_req_valid = issue;
  assign imem_req_addr  = pc;
  assign out_pc         = head_entry.pc;
  assign out_instr      = head_entry.instr;
  assign out_fault      = head_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model of the fetch front end.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_fault       (out_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] req_addr[$];
  int          req_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_fault[$];
  int          pop_cyc[$];
  int          red_cyc[$];

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ppc;
  logic        m_pend;
  logic        m_halt;
  logic        exp_req;
  logic        mem_v;
  logic [31:0] mem_a;

  function automatic logic [31:0] enc(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_addr.delete(); req_cyc.delete();
    pop_pc.delete(); pop_instr.delete(); pop_fault.delete(); pop_cyc.delete();
    red_cyc.delete();
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: every request accepted at a rising edge is answered for exactly the next cycle.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_v = imem_req_valid & reset_n;
      mem_a = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = mem_v;
      imem_resp_data  = mem_v ? enc(mem_a) : 32'h0;
    end
  end

  // Reference model and per-cycle comparison, evaluated mid-cycle on stable inputs.
  initial begin
    m_q.delete(); m_pc = RV; m_ppc = RV; m_pend = 1'b0; m_halt = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        m_q.delete(); m_pend = 1'b0; m_halt = 1'b0; m_pc = RV;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RV);
        chk("rst_out_valid", out_valid, 0);
      end else begin
        exp_req = !m_halt && !redirect_valid && ((m_q.size() + int'(m_pend)) < DEPTH);
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
          chk("out_pc", out_pc, m_q[0].pc);
          chk("out_instr", out_instr, m_q[0].instr);
          chk("out_fault", out_fault, m_q[0].fault);
        end
        if (imem_req_valid) begin
          req_addr.push_back(imem_req_addr);
          req_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
          pop_pc.push_back(out_pc);
          pop_instr.push_back(out_instr);
          pop_fault.push_back(out_fault);
          pop_cyc.push_back(cyc);
        end
        if (redirect_valid) red_cyc.push_back(cyc);

        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (redirect_valid) begin
          m_q.delete();
          m_pend = 1'b0;
          m_pc   = redirect_pc;
          m_halt = (redirect_pc[1:0] != 2'b00);
          if (m_halt) m_q.push_back('{redirect_pc, 32'h0000_0013, 1'b1});
        end else begin
          if (m_pend) m_q.push_back('{m_ppc, enc(m_ppc), 1'b0});
          m_pend = exp_req;
          if (exp_req) begin
            m_ppc = m_pc;
            m_pc  = m_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_req_addr", imem_req_addr, RV);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_out_fault", out_fault, 0);
    step(); step();

    // Streaming from reset with decode always ready.
    clear_logs();
    reset_n = 1'b1;
    repeat (8) step();
    chk("t1_req0", req_addr[0], 32'h0);
    chk("t1_req1", req_addr[1], 32'h4);
    chk("t1_req2", req_addr[2], 32'h8);
    chk("t1_req_gap1", req_cyc[1] - req_cyc[0], 1);
    chk("t1_req_gap2", req_cyc[2] - req_cyc[1], 1);
    chk("t1_first_out_lat", pop_cyc[0] - req_cyc[0], 2);
    chk("t1_first_out_pc", pop_pc[0], 32'h0);
    chk("t1_first_out_instr", pop_instr[0], 32'hC0DE_0000);
    chk("t1_out_gap", pop_cyc[1] - pop_cyc[0], 1);
    chk("t1_out_pc1", pop_pc[1], 32'h4);

    // Mid-stream reset with a response in flight: outputs clear without a clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_req_valid", imem_req_valid, 0);
    chk("t6_async_req_addr", imem_req_addr, RV);
    chk("t6_async_out_valid", out_valid, 0);
    chk("t6_async_out_pc", out_pc, 32'h0);
    chk("t6_async_out_instr", out_instr, 32'h0);
    step();

    // Backpressure from reset.
    clear_logs();
    out_ready = 1'b0;
    reset_n = 1'b1;
    repeat (10) step();
    chk("t2_req_count", req_addr.size(), 4);
    chk("t6_restart_addr", req_addr[0], RV);
    chk("t2_req3", req_addr[3], 32'hC);
    out_ready = 1'b1;
    repeat (10) step();
    chk("t2_resume_addr", req_addr[4], 32'h10);
    chk("t2_resume_cyc", req_cyc[4], pop_cyc[0] + 1);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_pop_pc%0d", i), pop_pc[i], 32'(4 * i));

    // Redirect with three buffered entries and a response in flight.
    reset_n = 1'b0;
    step();
    clear_logs();
    out_ready = 1'b0;
    reset_n = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("t3_req_before", req_addr.size() >= 5, 1);
    chk("t3_target_addr", req_addr[4], 32'h100);
    chk("t3_target_cyc", req_cyc[4], red_cyc[0] + 1);
    chk("t3_first_pc", pop_pc[0], 32'h100);
    chk("t3_first_cyc", pop_cyc[0], red_cyc[0] + 3);
    chk("t3_first_instr", pop_instr[0], 32'hC0DE_0100);

    // Misaligned redirect, then a two-cycle aligned redirect resumes fetch.
    out_ready = 1'b0;
    step();
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    chk("t4_fault_pops", pop_pc.size(), 1);
    chk("t4_fault_flag", pop_fault[0], 1);
    chk("t4_fault_pc", pop_pc[0], 32'h102);
    chk("t4_fault_instr", pop_instr[0], 32'h13);
    chk("t4_fault_cyc", pop_cyc[0], red_cyc[0] + 1);
    chk("t4_no_requests", req_addr.size(), 0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); step();
    redirect_valid = 1'b0;
    repeat (6) step();
    chk("t4_redirects", red_cyc.size(), 3);
    chk("t4_resume_addr", req_addr[0], 32'h200);
    chk("t4_resume_cyc", req_cyc[0], red_cyc[2] + 1);
    chk("t4_resume_pc", pop_pc[1], 32'h200);
    chk("t4_resume_out_cyc", pop_cyc[1], red_cyc[2] + 3);

    // PC wrap at the top of the address space.
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    chk("t5_wrap0", req_addr[0], 32'hFFFF_FFF8);
    chk("t5_wrap1", req_addr[1], 32'hFFFF_FFFC);
    chk("t5_wrap2", req_addr[2], 32'h0000_0000);
    chk("t5_wrap_cyc", req_cyc[0], red_cyc[0] + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
